dcm_lock_ctrl: RTL

//  Sequences a DCM clock generator: holds DCM RST for a minimum time, waits for LOCKED

---
 rtl/dcm_lock_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dcm_lock_ctrl.sv
// DCM start-up sequencer: RST pulse, lock wait with bounded retry, settle, then
// release of the downstream reset; also serialises single fine phase-shift steps.
module dcm_lock_ctrl #(
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int SETTLE_CYCLES = 16,
  parameter int MAX_RETRIES   = 7,
  parameter int PS_TIMEOUT    = 1023
) (
  input  logic       CLKIN,
  input  logic       RST,
  output logic       dcm_rst,
  input  logic       dcm_locked,
  input  logic       dcm_status,
  output logic       dcm_psen,
  output logic       dcm_psincdec,
  input  logic       dcm_psdone,
  input  logic       ps_req,
  input  logic       ps_dir,
  output logic       ps_ack,
  output logic       ps_err,
  output logic       sys_rst,
  output logic       locked,
  output logic       fail,
  output logic [2:0] retry_cnt
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int PW = $clog2(PS_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_RESET_DCM, S_WAIT_LOCK, S_SETTLE, S_RUN, S_PS_WAIT, S_FAIL
  } state_t;

  state_t        state, nxt;
  logic [1:0]    lk_sync;
  logic          lk, lost;
  logic [RW-1:0] rcnt;
  logic [LW-1:0] lcnt;
  logic [SW-1:0] scnt;
  logic [PW-1:0] pcnt;
  logic          issue, ack_n, err_n, timeout;

  always_ff @(posedge CLKIN or posedge RST) begin
    if (RST) lk_sync <= '0;
    else     lk_sync <= {lk_sync[0], dcm_locked};
  end

  assign lk   = lk_sync[1];
  assign lost = !lk || dcm_status;

  always_comb begin
    nxt     = state;
    issue   = 1'b0;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    timeout = 1'b0;
    case (state)
      S_RESET_DCM: if (rcnt == RW'(RST_CYCLES - 1)) nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (lk) nxt = S_SETTLE;
        else if (lcnt == LW'(LOCK_TIMEOUT - 1)) begin
          timeout = 1'b1;
          nxt     = (retry_cnt == 3'(MAX_RETRIES)) ? S_FAIL : S_RESET_DCM;
        end
      end
      S_SETTLE: begin
        if (lost) nxt = S_RESET_DCM;
        else if (scnt == SW'(SETTLE_CYCLES - 1)) nxt = S_RUN;
      end
      S_RUN: begin
        if (lost) nxt = S_RESET_DCM;
        else if (ps_req) begin
          issue = 1'b1;
          nxt   = S_PS_WAIT;
        end
      end
      // lock loss outranks a simultaneous psdone; psdone outranks the timeout
      S_PS_WAIT: begin
        if (lost) begin
          err_n = 1'b1;
          nxt   = S_RESET_DCM;
        end else if (dcm_psdone) begin
          ack_n = 1'b1;
          nxt   = S_RUN;
        end else if (pcnt == PW'(PS_TIMEOUT - 1)) begin
          err_n = 1'b1;
          nxt   = S_RUN;
        end
      end
      S_FAIL:  nxt = S_FAIL;
      default: nxt = S_RESET_DCM;
    endcase
  end

  always_ff @(posedge CLKIN or posedge RST) begin
    if (RST) begin
      state        <= S_RESET_DCM;
      rcnt         <= '0;
      lcnt         <= '0;
      scnt         <= '0;
      pcnt         <= '0;
      retry_cnt    <= '0;
      dcm_psen     <= 1'b0;
      dcm_psincdec <= 1'b0;
      ps_ack       <= 1'b0;
      ps_err       <= 1'b0;
    end else begin
      state <= nxt;
      rcnt  <= (state == S_RESET_DCM && nxt == S_RESET_DCM) ? rcnt + RW'(1) : '0;
      lcnt  <= (state == S_WAIT_LOCK && nxt == S_WAIT_LOCK) ? lcnt + LW'(1) : '0;
      pcnt  <= (state == S_PS_WAIT   && nxt == S_PS_WAIT)   ? pcnt + PW'(1) : '0;
      // the lock-detect cycle in WAIT_LOCK is the first qualifying settle cycle
      if (state == S_WAIT_LOCK && nxt == S_SETTLE) scnt <= SW'(!dcm_status);
      else if (state == S_SETTLE && nxt == S_SETTLE) scnt <= scnt + SW'(1);
      else scnt <= '0;
      if (timeout && nxt == S_RESET_DCM)     retry_cnt <= retry_cnt + 3'd1;
      else if (state == S_SETTLE && nxt == S_RUN) retry_cnt <= '0;
      dcm_psen <= issue;
      if (issue) dcm_psincdec <= ps_dir;
      ps_ack <= ack_n;
      ps_err <= err_n;
    end
  end

  assign dcm_rst = (state == S_RESET_DCM) || (state == S_FAIL);
  assign locked  = (state == S_RUN) || (state == S_PS_WAIT);
  assign sys_rst = !locked;
  assign fail    = (state == S_FAIL);

endmodule
